// File: rtl/cpu_phase_ctrl.sv
// cpu_phase_ctrl: four-phase instruction sequencer that owns the program counter
// and the saturating retired-instruction count.
module cpu_phase_ctrl #(
   parameter logic [7:0] RESET_PC    = 8'd0,
   parameter int         COUNT_WIDTH = 16
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   START,
   input  logic                   STEP_MODE,
   input  logic                   JUMP_EN,
   input  logic [7:0]             JUMP_ADDR,
   input  logic                   HALT_REQ,
   output logic                   EN_FT,
   output logic                   EN_DC,
   output logic                   EN_EX,
   output logic                   EN_WB,
   output logic [7:0]             P_COUNT,
   output logic                   RUNNING,
   output logic                   HALTED,
   output logic [COUNT_WIDTH-1:0] INSTR_COUNT
);
   typedef enum logic [2:0] {S_IDLE, S_FT, S_DC, S_EX, S_WB, S_HALT} state_t;
   state_t                 state_q;
   logic [7:0]             pc_q, pc_d, addr_q;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   jmp_q, hlt_q;
   // Halt keeps the PC where it is; otherwise jump wins over sequential increment.
   assign pc_d  = hlt_q ? pc_q : jmp_q ? addr_q : pc_q + 8'd1;
   assign cnt_d = &cnt_q ? cnt_q : cnt_q + COUNT_WIDTH'(1);
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
         jmp_q   <= 1'b0;
         hlt_q   <= 1'b0;
         addr_q  <= 8'd0;
      end else begin
         case (state_q)
            S_IDLE: state_q <= START ? S_FT : S_IDLE;
            S_FT:   state_q <= S_DC;
            S_DC:   state_q <= S_EX;
            S_EX: begin
               jmp_q   <= JUMP_EN;
               addr_q  <= JUMP_ADDR;
               hlt_q   <= HALT_REQ;
               state_q <= S_WB;
            end
            S_WB: begin
               cnt_q   <= cnt_d;
               pc_q    <= pc_d;
               state_q <= hlt_q ? S_HALT : STEP_MODE ? S_IDLE : S_FT;
            end
            S_HALT: state_q <= S_HALT;
            default: state_q <= S_IDLE;
         endcase
      end
   end
   assign EN_FT       = state_q == S_FT;
   assign EN_DC       = state_q == S_DC;
   assign EN_EX       = state_q == S_EX;
   assign EN_WB       = state_q == S_WB;
   assign RUNNING     = EN_FT | EN_DC | EN_EX | EN_WB;
   assign HALTED      = state_q == S_HALT;
   assign P_COUNT     = pc_q;
   assign INSTR_COUNT = cnt_q;
endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// tb_cpu_phase_ctrl: vector table with an expected-output scoreboard, covering
// sequencing, jumps, halt priority, step mode, PC wrap, mid-op reset and count saturation.
module tb_cpu_phase_ctrl;
   typedef struct {
      bit         b, rst, start, step, jen, hr;
      logic [7:0] ja;
      logic [3:0] en;
      logic [7:0] pc;
      bit         run, hlt;
      int         cnt;
      string      tag;
   } vec_t;
   localparam logic [3:0] FT = 4'b1000, DC = 4'b0100, EX = 4'b0010, WB = 4'b0001, NO = 4'b0000;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic       rst_a = 1'b1, start_a = 1'b0, step_a = 1'b0, jen_a = 1'b0, hr_a = 1'b0;
   logic [7:0] ja_a = 8'd0;
   logic       rst_b = 1'b1, start_b = 1'b0, step_b = 1'b0, jen_b = 1'b0, hr_b = 1'b0;
   logic [7:0] ja_b = 8'd0;
   logic       ft_a, dc_a, ex_a, wb_a, run_a, hlt_a, ft_b, dc_b, ex_b, wb_b, run_b, hlt_b;
   logic [7:0] pc_a, pc_b;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;
   cpu_phase_ctrl dut_a (
      .CLK(clk), .RESET(rst_a), .START(start_a), .STEP_MODE(step_a), .JUMP_EN(jen_a),
      .JUMP_ADDR(ja_a), .HALT_REQ(hr_a), .EN_FT(ft_a), .EN_DC(dc_a), .EN_EX(ex_a), .EN_WB(wb_a),
      .P_COUNT(pc_a), .RUNNING(run_a), .HALTED(hlt_a), .INSTR_COUNT(cnt_a)
   );
   cpu_phase_ctrl #(.RESET_PC(8'd254), .COUNT_WIDTH(4)) dut_b (
      .CLK(clk), .RESET(rst_b), .START(start_b), .STEP_MODE(step_b), .JUMP_EN(jen_b),
      .JUMP_ADDR(ja_b), .HALT_REQ(hr_b), .EN_FT(ft_b), .EN_DC(dc_b), .EN_EX(ex_b), .EN_WB(wb_b),
      .P_COUNT(pc_b), .RUNNING(run_b), .HALTED(hlt_b), .INSTR_COUNT(cnt_b)
   );
   vec_t  vecs[$];
   vec_t  exp_q[$];
   int    checks = 0, failures = 0;
   string tag_s;
   bit    sel_b;
   // Each vector: inputs applied for one cycle, outputs expected just after that edge.
   task automatic add(bit rst, bit start, bit step, bit jen, logic [7:0] ja, bit hr,
                      logic [3:0] en, logic [7:0] pc, bit run, bit hlt, int cnt);
      vec_t v;
      v.b = sel_b; v.rst = rst; v.start = start; v.step = step; v.jen = jen; v.ja = ja; v.hr = hr;
      v.en = en; v.pc = pc; v.run = run; v.hlt = hlt; v.cnt = cnt; v.tag = tag_s;
      vecs.push_back(v);
   endtask
   // One instruction: dj drives jump+halt during DC (must be ignored), ej/eh during EX.
   task automatic ins(logic [7:0] pc, int cnt, bit step, bit st_ex, bit dj, bit ej, bit eh,
                      logic [7:0] ja);
      add(0, 1, step, 0, 8'd0, 0, FT, pc, 1, 0, cnt);
      add(0, 0, step, 0, 8'd0, 0, DC, pc, 1, 0, cnt);
      add(0, 0, step, dj, ja, dj, EX, pc, 1, 0, cnt);
      add(0, st_ex, step, ej, ja, eh, WB, pc, 1, 0, cnt);
   endtask
   task automatic drive(vec_t v);
      rst_a = v.b ? 1'b1 : v.rst; start_a = !v.b && v.start; step_a = !v.b && v.step;
      jen_a = !v.b && v.jen; hr_a = !v.b && v.hr; ja_a = v.b ? 8'd0 : v.ja;
      rst_b = v.b ? v.rst : 1'b1; start_b = v.b && v.start; step_b = v.b && v.step;
      jen_b = v.b && v.jen; hr_b = v.b && v.hr; ja_b = v.b ? v.ja : 8'd0;
   endtask
   task automatic compare(int idx);
      vec_t       e;
      logic [3:0] en;
      logic [7:0] pc;
      logic       run, hlt;
      int         cnt;
      e   = exp_q.pop_front();
      en  = e.b ? {ft_b, dc_b, ex_b, wb_b} : {ft_a, dc_a, ex_a, wb_a};
      pc  = e.b ? pc_b : pc_a;
      run = e.b ? run_b : run_a;
      hlt = e.b ? hlt_b : hlt_a;
      cnt = e.b ? int'(cnt_b) : int'(cnt_a);
      checks++;
      if (en !== e.en || pc !== e.pc || run !== e.run || hlt !== e.hlt || cnt != e.cnt) begin
         failures++;
         $display("FAIL %s vec %0d: got en=%b pc=%0d run=%b halt=%b cnt=%0d, expected en=%b pc=%0d run=%b halt=%b cnt=%0d",
                  e.tag, idx, en, pc, run, hlt, cnt, e.en, e.pc, e.run, e.hlt, e.cnt);
      end
   endtask
   initial begin
      sel_b = 0;
      tag_s = "reset";
      repeat (2) add(1, 0, 0, 0, 8'd0, 0, NO, 8'd0, 0, 0, 0);
      tag_s = "seq";
      for (int k = 0; k < 13; k++) ins(8'(k), k, 0, 0, 0, 0, 0, 8'd0);
      tag_s = "jump";
      ins(8'd13, 13, 0, 0, 0, 1, 0, 8'd8);
      tag_s = "dc_jump_ignored";
      ins(8'd8, 14, 0, 0, 1, 0, 0, 8'd20);
      tag_s = "jump_back";
      ins(8'd9, 15, 0, 0, 0, 1, 0, 8'd13);
      tag_s = "dc_halt_ignored";
      ins(8'd13, 16, 0, 0, 1, 0, 0, 8'd3);
      tag_s = "halt_priority";
      ins(8'd14, 17, 0, 0, 0, 1, 1, 8'd3);
      add(0, 0, 0, 0, 8'd0, 0, NO, 8'd14, 0, 1, 18);
      tag_s = "halt_start";
      for (int k = 0; k < 3; k++) begin
         add(0, 1, 0, 0, 8'd0, 0, NO, 8'd14, 0, 1, 18);
         add(0, 0, 0, 0, 8'd0, 0, NO, 8'd14, 0, 1, 18);
      end
      tag_s = "halt_reset";
      add(1, 0, 0, 0, 8'd0, 0, NO, 8'd0, 0, 0, 0);
      tag_s = "step";
      for (int p = 0; p < 3; p++) begin
         ins(8'(p), p, 1, 1, 0, 0, 0, 8'd0);
         repeat (6) add(0, 0, 1, 0, 8'd0, 0, NO, 8'(p + 1), 0, 0, p + 1);
      end
      sel_b = 1;
      tag_s = "b_reset";
      repeat (2) add(1, 0, 0, 0, 8'd0, 0, NO, 8'd254, 0, 0, 0);
      tag_s = "wrap";
      ins(8'd254, 0, 0, 0, 0, 0, 0, 8'd0);
      ins(8'd255, 1, 0, 0, 0, 0, 0, 8'd0);
      add(0, 1, 0, 0, 8'd0, 0, FT, 8'd0, 1, 0, 2);
      add(0, 0, 0, 0, 8'd0, 0, DC, 8'd0, 1, 0, 2);
      add(0, 0, 0, 0, 8'd0, 0, EX, 8'd0, 1, 0, 2);
      tag_s = "reset_mid_ex";
      add(1, 0, 0, 0, 8'd0, 0, NO, 8'd254, 0, 0, 0);
      tag_s = "saturate";
      for (int k = 0; k < 20; k++) ins(8'(254 + k), k > 15 ? 15 : k, 0, 0, 0, 0, 0, 8'd0);
      add(0, 1, 0, 0, 8'd0, 0, FT, 8'd18, 1, 0, 15);
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i]);
         exp_q.push_back(vecs[i]);
         @(posedge clk);
         #1;
         compare(i);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cpu_phase_ctrl.md
# cpu_phase_ctrl

Instruction-phase sequencer and program-counter owner for the cpu15 core. It steps each instruction through four phases (fetch, decode, execute, write-back) and drives a one-hot phase enable per stage. It holds and updates `P_COUNT` for the program ROM, applying sequential increment, jumps reported by the execute stage, halt, and single-step operation.

## Interface
- `RESET_PC`, 8'd0, value loaded into `P_COUNT` on reset.
- `COUNT_WIDTH`, 16, width of the retired-instruction counter.

- `CLK`  in  1  single system clock; all state updates on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `START`  in  1  level sampled in IDLE; begins the next instruction.
- `STEP_MODE`  in  1  1 = return to IDLE after each instruction; 0 = free-run.
- `JUMP_EN`  in  1  from execute stage, sampled only in EX; take branch.
- `JUMP_ADDR`  in  8  branch target, sampled with `JUMP_EN`.
- `HALT_REQ`  in  1  from decoder (hlt), sampled only in EX.
- `EN_FT`  out  1  high for the FT-phase cycle.
- `EN_DC`  out  1  high for the DC-phase cycle.
- `EN_EX`  out  1  high for the EX-phase cycle.
- `EN_WB`  out  1  high for the WB-phase cycle.
- `P_COUNT`  out  8  current instruction address.
- `RUNNING`  out  1  high in FT/DC/EX/WB.
- `HALTED`  out  1  high in HALT.
- `INSTR_COUNT`  out  COUNT_WIDTH  completed instructions, saturating.

## Operation
- States: IDLE, FT, DC, EX, WB, HALT. State register one-hot or encoded; outputs are decoded from the registered state, so they are glitch-free.
- Reset (any state, any phase): state=IDLE, `P_COUNT`=RESET_PC, `INSTR_COUNT`=0, jump/halt latches cleared, all EN_* = 0, `RUNNING`=0, `HALTED`=0. Reset mid-instruction aborts it with no PC update and no count.
- IDLE: if `START`=1, go to FT; otherwise stay.
- Phase order: FT -> DC -> EX -> WB. One cycle each, with no stalls.
- EX: latch `JUMP_EN`, `JUMP_ADDR`, `HALT_REQ`. These inputs are ignored in every other state.
- WB exit:
  - `INSTR_COUNT` += 1. It saturates at all-ones and never wraps.
  - If halt latched: go to HALT. `P_COUNT` is unchanged, and any jump is discarded (halt has priority over jump).
  - Else if jump latched: `P_COUNT` = latched `JUMP_ADDR`.
  - Else: `P_COUNT` = `P_COUNT`+1 mod 256 (255 -> 0 wraps silently).
  - Next state: FT if `STEP_MODE`=0, IDLE if `STEP_MODE`=1. `STEP_MODE` is sampled only here.
- HALT: terminal. `START` is ignored. Only `RESET` exits.
- `START` outside IDLE: ignored, not queued.
- A jump to the current address (e.g. `jmp` to itself) is legal and loops indefinitely.

## Timing
- Instruction latency is 4 cycles in free-run mode. Throughput is one instruction per 4 cycles.
- `START` high at edge n while in IDLE -> `EN_FT`=1 in cycle n+1, `EN_DC` n+2, `EN_EX` n+3, `EN_WB` n+4.
- `P_COUNT` is stable from FT through WB of an instruction. The new value appears in the cycle after WB, which in free-run is the next FT cycle.
- The downstream fetch stage registers ROM output on the FT edge. Instruction data is valid from DC onward.
- Step mode: each instruction is 1 IDLE-exit cycle plus 4 phase cycles. `START` held high acts as free-run with one IDLE cycle inserted per instruction.
- `HALTED`=1 from the cycle after the halting WB. `RUNNING` falls in the same cycle.
- Exactly one EN_* is high whenever `RUNNING`=1. All EN_* are 0 in IDLE and HALT.

## Test plan
- Reset and sequence: RESET 2 cycles, then START=1, STEP_MODE=0, no jump/halt for 12 cycles -> EN pattern FT,DC,EX,WB repeats 3 times; `P_COUNT` 0,1,2,3 at each FT; `INSTR_COUNT`=3.
- Jump: `JUMP_EN`=1, `JUMP_ADDR`=8 during EX of the instruction at PC=13 -> next FT sees `P_COUNT`=8. Same inputs asserted during DC only -> ignored, next PC=14.
- Halt priority: `HALT_REQ`=1 and `JUMP_EN`=1 (addr 3) in EX at PC=14 -> HALT, `P_COUNT`=14, `HALTED`=1, all EN_* 0. START pulses ignored. RESET -> IDLE, `P_COUNT`=0.
- Step mode: STEP_MODE=1, one-cycle START pulses spaced 10 cycles apart -> exactly one FT..WB per pulse, then IDLE; PC advances by 1 per pulse. START asserted during EX is ignored.
- Wrap and reset mid-op: RESET_PC=8'd254, free-run -> PC sequence 254,255,0,1. Assert RESET during EX of the instruction at PC=0 -> next cycle IDLE, `P_COUNT`=254, `INSTR_COUNT`=0.
- Saturation: COUNT_WIDTH=4, free-run 20 instructions -> `INSTR_COUNT` holds at 15.
